ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame, device ack check.
// Optional watchdog for SEND/ACK is compiled in with `define PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int CLK_HOLD_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES  = 750000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int HOLD_W = $clog2(CLK_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_SEND = 3'd2,
        S_ACK  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [8:0]          r_frame;
    logic [8:0]          w_frame_nxt;
    logic [3:0]          r_bit_cnt;
    logic [3:0]          w_bit_cnt_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic                r_clk_oe, w_clk_oe_nxt;
    logic                r_dat_oe, w_dat_oe_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_error, w_error_nxt;

    logic                r_clk_meta, r_clk_sync, r_clk_prev;
    logic                r_dat_meta, r_dat_sync;
    logic                w_fall;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]     r_wdog;
    logic [WD_W-1:0]     w_wdog_nxt;
    logic                w_wdog_expired;
    assign w_wdog_expired = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    assign w_fall     = r_clk_prev & ~r_clk_sync;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign tx_error   = r_error;

    // Line synchronizers; idle lines are pulled high, so they reset to 1.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat_in;
            r_dat_sync <= r_dat_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_frame    <= 9'd0;
            r_bit_cnt  <= 4'd0;
            r_hold_cnt <= HOLD_W'(0);
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            r_wdog     <= WD_W'(0);
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_frame    <= w_frame_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_dat_oe   <= w_dat_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            r_wdog     <= w_wdog_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_frame_nxt    = r_frame;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_clk_oe_nxt   = r_clk_oe;
        w_dat_oe_nxt   = r_dat_oe;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        w_wdog_nxt     = r_wdog;
`endif

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                if (tx_start) begin
                    w_frame_nxt    = {odd_parity(tx_data), tx_data};
                    w_bit_cnt_nxt  = 4'd0;
                    w_hold_cnt_nxt = HOLD_W'(CLK_HOLD_CYCLES - 1);
                    w_clk_oe_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_HOLD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_HOLD: begin
                if (r_hold_cnt == HOLD_W'(0)) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b1;
                    w_state_nxt  = S_SEND;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    w_wdog_nxt   = WD_W'(0);
`endif
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end

            S_SEND: begin
                if (w_fall) begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    w_wdog_nxt = WD_W'(0);
`endif
                    // Falls 1..9 shift out data then parity; fall 10 releases for stop.
                    if (r_bit_cnt < 4'd9) begin
                        w_dat_oe_nxt  = ~r_frame[r_bit_cnt];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else begin
                        w_dat_oe_nxt = 1'b0;
                        w_state_nxt  = S_ACK;
                    end
                end else begin
                    w_state_nxt = S_SEND;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    if (w_wdog_expired) begin
                        w_clk_oe_nxt = 1'b0;
                        w_dat_oe_nxt = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_error_nxt  = 1'b1;
                        w_state_nxt  = S_FIN;
                    end else begin
                        w_wdog_nxt = r_wdog + WD_W'(1);
                    end
`endif
                end
            end

            S_ACK: begin
                if (w_fall) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_FIN;
                    if (r_dat_sync == 1'b0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_ACK;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    if (w_wdog_expired) begin
                        w_clk_oe_nxt = 1'b0;
                        w_dat_oe_nxt = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_error_nxt  = 1'b1;
                        w_state_nxt  = S_FIN;
                    end else begin
                        w_wdog_nxt = r_wdog + WD_W'(1);
                    end
`endif
                end
            end

            S_FIN: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                if (r_clk_sync && r_dat_sync) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FIN;
                end
            end

            default: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// expected frames/results come from a byte-level reference model.
module tb_ps2_host_tx;

    localparam int HOLD     = 8;
    localparam int TOUT     = 200;
    localparam int HALF     = 20;
    // Two synchronizer flops plus the edge that acts on the detected fall.
    localparam int SYNC_LAT = 3;

    logic       CLOCK_50 = 1'b0;
    logic       Reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       dev_clk;
    logic       dev_dat;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       tx_busy, tx_done, tx_error;

    // Open-collector bus: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    typedef struct {
        logic [10:0] frame;
        logic        chk_frame;
        logic        exp_done;
        logic        is_to;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests    = 0;
    int          n_fail     = 0;
    int          n_pulses   = 0;
    int          n_expected = 0;
    int          cyc        = 0;
    int          to_exp_cyc = 0;
    int          obs_hold   = 0;
    logic [10:0] obs_frame  = 11'd0;

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Line-level frame as the device sees it: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic issue(input logic [7:0] d, input logic ack, input logic chk,
                         input logic is_to, input logic push);
        exp_t e;
        if (push) begin
            e.frame     = model_frame(d);
            e.chk_frame = chk;
            e.exp_done  = ~ack;
            e.is_to     = is_to;
            sb_q.push_back(e);
            n_expected++;
        end
        @(negedge CLOCK_50);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge CLOCK_50);
        tx_start = 1'b0;
    endtask

    // Device model: measures the request-to-send hold, then generates up to 11 clocks,
    // sampling the data line at the end of each high phase; stop_at > 0 stops after that fall.
    task automatic device_xfer(input logic ack, input int stop_at);
        int w;
        w = 0;
        while (!ps2_clk_oe && w < 50) begin
            @(negedge CLOCK_50);
            w++;
        end
        check("hold_start", ps2_clk_oe, 1);
        if (!ps2_clk_oe) return;
        obs_hold = 0;
        while (ps2_clk_oe && obs_hold < 1000) begin
            obs_hold++;
            @(negedge CLOCK_50);
        end
        repeat (10) @(negedge CLOCK_50);
        for (int k = 1; k <= 11; k++) begin
            repeat (HALF) @(negedge CLOCK_50);
            obs_frame[k-1] = ps2_dat_in;
            if (k == 11) begin
                dev_dat = ack;
                repeat (2) @(negedge CLOCK_50);
            end
            dev_clk = 1'b0;
            if (k == stop_at) to_exp_cyc = cyc + SYNC_LAT + TOUT;
            repeat (HALF) @(negedge CLOCK_50);
            dev_clk = 1'b1;
            if (k == 11) dev_dat = 1'b1;
            if (k == stop_at) break;
        end
    endtask

    // Monitor: pops the scoreboard on every done/error pulse and checks bus invariants.
    initial begin
        logic prev_pulse;
        exp_t e;
        prev_pulse = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (prev_pulse) begin
                check("after_pulse", {tx_done, tx_error, tx_busy}, 3'b000);
                prev_pulse = 1'b0;
            end
            if (ps2_clk_oe && ps2_dat_oe) flag("both_oe");
            if (tx_done && tx_error) flag("done_and_error");
            if (tx_done || tx_error) begin
                prev_pulse = 1'b1;
                n_pulses++;
                if (sb_q.size() == 0) begin
                    flag("unexpected_pulse");
                end else begin
                    e = sb_q.pop_front();
                    check("result_done", tx_done, e.exp_done);
                    check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
                    check("hold_len", obs_hold, HOLD);
                    if (e.chk_frame) check("frame", obs_frame, e.frame);
                    if (e.is_to) check("timeout_cycle", cyc, to_exp_cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic [7:0] d;
        logic       a;
        Reset    = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        Reset    = 1'b0;
        tx_start = 1'b0;
        @(negedge CLOCK_50);
        check("start_in_reset_ignored", {ps2_clk_oe, tx_busy}, 2'b00);

        // Acked and nacked reference frames.
        issue(8'hED, 1'b0, 1'b1, 1'b0, 1'b1);
        check("busy_in_hold", tx_busy, 1);
        device_xfer(1'b0, 0);
        repeat (10) @(negedge CLOCK_50);
        issue(8'hF4, 1'b1, 1'b1, 1'b0, 1'b1);
        device_xfer(1'b1, 0);
        repeat (10) @(negedge CLOCK_50);

        // tx_start held with random data throughout the transfer must be ignored.
        issue(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        fork
            begin
                repeat (300) begin
                    @(negedge CLOCK_50);
                    tx_start = 1'b1;
                    tx_data  = 8'($urandom);
                end
                @(negedge CLOCK_50);
                tx_start = 1'b0;
            end
            device_xfer(1'b0, 0);
        join
        seen = 1'b0;
        repeat (100) begin
            @(negedge CLOCK_50);
            if (ps2_clk_oe) seen = 1'b1;
        end
        check("single_frame", seen, 0);

        // Reset after fall 5 aborts silently; next frame completes.
        issue(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        device_xfer(1'b0, 5);
        Reset = 1'b1;
        @(negedge CLOCK_50);
        check("abort_state", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}, 5'b00000);
        Reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        issue(8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        device_xfer(1'b0, 0);
        repeat (10) @(negedge CLOCK_50);

        // Device stops clocking after fall 3.
`ifdef PS2_HOST_TX_TIMEOUT_EN
        issue(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        device_xfer(1'b0, 3);
        repeat (250) @(negedge CLOCK_50);
        check("idle_after_timeout", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b000);
`else
        issue(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        device_xfer(1'b0, 3);
        repeat (400) @(negedge CLOCK_50);
        check("busy_held_no_watchdog", tx_busy, 1);
        Reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        Reset = 1'b0;
`endif
        repeat (10) @(negedge CLOCK_50);

        // Random frames with random ack/nack.
        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom);
            a = 1'($urandom_range(0, 1));
            issue(d, a, 1'b1, 1'b0, 1'b1);
            device_xfer(a, 0);
            repeat (10) @(negedge CLOCK_50);
        end

        repeat (20) @(negedge CLOCK_50);
        check("pulse_count", n_pulses, n_expected);
        check("queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
